// File: rtl/dds_sweep_sequencer.sv
// dds_sweep_sequencer: steps the DDS table address from start_addr to stop_addr (clamped, no wrap), dwelling 'dwell' Ready pulses per step and pulsing FreqChng TABLE_LAT cycles after each address change; ports Fg_clk/Resetn (sync active-low), Start/Abort/Loop/Ready controls, start_addr/stop_addr/step/dwell config, address/FreqChng/Busy/Done outputs; define SWEEP_PINGPONG_EN to reverse direction at each looping end of sweep
module dds_sweep_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DWELL_W = 16,
  parameter int TABLE_LAT = 1
) (
  input  logic               Fg_clk,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Loop,
  input  logic               Ready,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  stop_addr,
  input  logic [ADDR_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [ADDR_W-1:0]  address,
  output logic               FreqChng,
  output logic               Busy,
  output logic               Done
);
  typedef enum logic [2:0] {IDLE, SETTLE, DWELL, STEP, DONE} state_t;
  localparam logic [1:0] LAT_LAST = 2'(TABLE_LAT - 1);
  localparam logic [1:0] LAT_END = 2'(TABLE_LAT);
  state_t r_state;
  logic [ADDR_W-1:0] r_start, r_stop, r_tgt, r_step;
  logic [DWELL_W-1:0] r_dwell, r_cnt;
  logic [1:0] r_lat;
  logic w_end;
  logic [ADDR_W-1:0] w_ntgt, w_next, w_loop;
  function automatic logic [ADDR_W-1:0] f_toward(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] t, input logic [ADDR_W-1:0] s);
    logic [ADDR_W:0] up, dn;
    up = {1'b0, a} + {1'b0, s};
    dn = {1'b0, a} - {1'b0, s};
    return (a < t) ? ((up > {1'b0, t}) ? t : up[ADDR_W-1:0])
                   : ((dn[ADDR_W] || dn[ADDR_W-1:0] < t) ? t : dn[ADDR_W-1:0]);
  endfunction
  always_comb begin
    w_end = address == r_tgt;
`ifdef SWEEP_PINGPONG_EN
    w_ntgt = w_end ? ((r_tgt == r_stop) ? r_start : r_stop) : r_tgt;
    w_next = f_toward(address, w_ntgt, r_step);
    w_loop = w_next;
`else
    w_ntgt = r_tgt;
    w_next = f_toward(address, r_tgt, r_step);
    w_loop = r_start;
`endif
  end
  always_ff @(posedge Fg_clk) begin
    if (!Resetn) begin
      r_state <= IDLE;
      address <= '0;
      FreqChng <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      r_start <= '0;
      r_stop <= '0;
      r_tgt <= '0;
      r_step <= '0;
      r_dwell <= '0;
      r_cnt <= '0;
      r_lat <= '0;
    end else if (Abort) begin
      r_state <= IDLE;
      FreqChng <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_start <= start_addr;
          r_stop <= stop_addr;
          r_tgt <= stop_addr;
          r_step <= (step == '0) ? ADDR_W'(1) : step;
          r_dwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
          address <= start_addr;
          r_lat <= '0;
          Busy <= 1'b1;
          r_state <= SETTLE;
        end
        SETTLE: begin
          r_lat <= r_lat + 1'b1;
          FreqChng <= r_lat == LAT_LAST;
          if (r_lat == LAT_END) begin
            r_cnt <= '0;
            r_state <= DWELL;
          end
        end
        DWELL: if (Ready) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt + 1'b1 == r_dwell) r_state <= STEP;
        end
        STEP: begin
          r_lat <= '0;
          if (w_end && !Loop) begin
            Busy <= 1'b0;
            Done <= 1'b1;
            r_state <= DONE;
          end else begin
            address <= w_end ? w_loop : w_next;
            r_tgt <= w_ntgt;
            r_state <= SETTLE;
          end
        end
        DONE: begin
          Done <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// tb_dds_sweep_sequencer: directed and random sweeps checked every cycle against an event-level model
module tb_dds_sweep_sequencer;
  localparam int TL = 1;
  logic Fg_clk, Resetn, Start, Abort, Loop, Ready;
  logic [10:0] start_addr, stop_addr, step, address;
  logic [15:0] dwell;
  logic FreqChng, Busy, Done;
  int checks = 0, errors = 0;
  int rp = 4, tcnt = 0, chk_on = 0, dut_dones = 0;
  int m_addr, m_busy, m_fc, m_done, m_wait, m_need, m_cnting, m_pend;
  int c_start, c_stop, c_tgt, c_step, c_dwell;
  int m_fcq[$];
  int ea[6];
  dds_sweep_sequencer #(.ADDR_W(11), .DWELL_W(16), .TABLE_LAT(TL)) dut (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .Start(Start), .Abort(Abort), .Loop(Loop), .Ready(Ready),
    .start_addr(start_addr), .stop_addr(stop_addr), .step(step), .dwell(dwell),
    .address(address), .FreqChng(FreqChng), .Busy(Busy), .Done(Done));
  initial Fg_clk = 1'b0;
  always #5 Fg_clk = ~Fg_clk;
  function automatic int toward(input int a, input int t, input int s);
    if (a < t) return (a + s > t) ? t : a + s;
    return (a - s < t) ? t : a - s;
  endfunction
  always @(posedge Fg_clk) begin
    if (!Resetn) begin
      m_addr = 0; m_busy = 0; m_fc = 0; m_done = 0; m_wait = 0; m_need = 0; m_cnting = 0; m_pend = 0;
      c_start = 0; c_stop = 0; c_tgt = 0; c_step = 0; c_dwell = 0;
    end else if (Abort) begin
      m_busy = 0; m_fc = 0; m_done = 0; m_wait = 0; m_cnting = 0; m_pend = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (Start) begin
        c_start = int'(start_addr); c_stop = int'(stop_addr); c_tgt = c_stop;
        c_step = (step == 0) ? 1 : int'(step);
        c_dwell = (dwell == 0) ? 1 : int'(dwell);
        m_addr = c_start; m_busy = 1; m_wait = TL;
      end
    end else if (m_pend) begin
      m_pend = 0;
      if (m_addr == c_tgt) begin
        if (Loop) begin
`ifdef SWEEP_PINGPONG_EN
          c_tgt = (c_tgt == c_stop) ? c_start : c_stop;
          m_addr = toward(m_addr, c_tgt, c_step);
`else
          m_addr = c_start;
`endif
          m_wait = TL;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_addr = toward(m_addr, c_tgt, c_step);
        m_wait = TL;
      end
    end else if (m_cnting) begin
      if (Ready) begin
        m_need--;
        if (m_need == 0) begin m_cnting = 0; m_pend = 1; end
      end
    end else if (m_fc) begin
      m_fc = 0; m_cnting = 1; m_need = c_dwell;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_fc = 1; m_fcq.push_back(m_addr); end
    end
  end
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge Fg_clk) if (chk_on) begin
    if (Done) dut_dones++;
    chk("address", int'(address), m_addr);
    chk("FreqChng", int'(FreqChng), m_fc);
    chk("Busy", int'(Busy), m_busy);
    chk("Done", int'(Done), m_done);
  end
  task automatic tick();
    @(negedge Fg_clk);
    tcnt++;
    Ready = (rp == 0) ? ($urandom_range(0, 2) == 0) : (tcnt % rp == 0);
  endtask
  task automatic sweep(input int s, input int e, input int st, input int dw, input int lp, input int r);
    start_addr = 11'(s); stop_addr = 11'(e); step = 11'(st); dwell = 16'(dw); Loop = lp[0]; rp = r;
    m_fcq.delete();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (!Done && n < budget) begin tick(); n++; end
    chk("done_seen", int'(Done), 1);
    tick();
  endtask
  task automatic chk_seq(input string n, input int len);
    chk({n, "_len"}, m_fcq.size(), len);
    for (int i = 0; i < len; i++) if (i < m_fcq.size()) chk(n, m_fcq[i], ea[i]);
  endtask
  initial begin
    int d0, held, n, len;
    Resetn = 1'b0; Start = 1'b0; Abort = 1'b0; Loop = 1'b0; Ready = 1'b0;
    start_addr = '0; stop_addr = '0; step = '0; dwell = '0;
    tick(); tick();
    chk_on = 1;
    Resetn = 1'b1;
    chk("rst_addr", int'(address), 0);
    chk("rst_busy", int'(Busy), 0);
    tick();
    d0 = dut_dones;
    sweep(10, 13, 1, 2, 0, 4);
    wait_done(400);
    ea = '{10, 11, 12, 13, 0, 0};
    chk_seq("t1_seq", 4);
    chk("t1_done_count", dut_dones - d0, 1);
    sweep(2040, 2047, 5, 1, 0, 0);
    wait_done(400);
    ea = '{2040, 2045, 2047, 0, 0, 0};
    chk_seq("t2_seq", 3);
    chk("t2_last_addr", int'(address), 2047);
    sweep(20, 5, 7, 0, 0, 3);
    wait_done(400);
    ea = '{20, 13, 6, 5, 0, 0};
    chk_seq("t3_seq", 4);
    d0 = dut_dones;
`ifdef SWEEP_PINGPONG_EN
    sweep(3, 5, 1, 1, 1, 0);
    ea = '{3, 4, 5, 4, 3, 4};
    len = 6;
`else
    sweep(3, 4, 1, 1, 1, 0);
    ea = '{3, 4, 3, 4, 0, 0};
    len = 4;
`endif
    n = 0;
    while (m_fcq.size() < len && n < 600) begin tick(); n++; end
    chk_seq("t4_seq", len);
    chk("t4_no_done", dut_dones - d0, 0);
    Abort = 1'b1; tick(); Abort = 1'b0;
    chk("t4_abort_busy", int'(Busy), 0);
    sweep(100, 110, 2, 3, 0, 2);
    n = 0;
    while (!FreqChng && n < 100) begin tick(); n++; end
    chk("t5_fc_seen", int'(FreqChng), 1);
    tick(); tick();
    held = 100;
    start_addr = 11'd900; stop_addr = 11'd0; Start = 1'b1; tick(); Start = 1'b0;
    chk("t5_start_ignored", int'(address), held);
    Abort = 1'b1; tick(); Abort = 1'b0;
    chk("t5_abort_busy", int'(Busy), 0);
    chk("t5_abort_addr", int'(address), held);
    chk("t5_abort_fc", int'(FreqChng), 0);
    start_addr = 11'd500; Start = 1'b1; Abort = 1'b1; tick(); Start = 1'b0; Abort = 1'b0;
    chk("t5_abst_busy", int'(Busy), 0);
    chk("t5_abst_addr", int'(address), held);
    tick(); tick();
    chk("t5_abst_idle", int'(Busy), 0);
    sweep(50, 60, 3, 1, 0, 3);
    Resetn = 1'b0; tick(); Resetn = 1'b1;
    chk("t6_addr", int'(address), 0);
    chk("t6_busy", int'(Busy), 0);
    chk("t6_fc", int'(FreqChng), 0);
    chk("t6_done", int'(Done), 0);
    sweep(7, 9, 1, 1, 0, 2);
    wait_done(300);
    ea = '{7, 8, 9, 0, 0, 0};
    chk_seq("t6_seq", 3);
    rp = 0;
    for (int i = 0; i < 6000; i++) begin
      int s;
      s = int'($urandom_range(0, 2047));
      start_addr = 11'(s);
      stop_addr = 11'(($urandom_range(0, 1) == 1) ? ((s + int'($urandom_range(0, 40)) > 2047) ? 2047 : s + int'($urandom_range(0, 40)))
                                                  : ((s - int'($urandom_range(0, 40)) < 0) ? 0 : s - int'($urandom_range(0, 40))));
      step = 11'($urandom_range(0, 12));
      dwell = 16'($urandom_range(0, 3));
      Loop = ($urandom_range(0, 3) == 0);
      Abort = ($urandom_range(0, 199) == 0);
      Start = ($urandom_range(0, 29) == 0);
      Resetn = ($urandom_range(0, 999) != 0);
      tick();
    end
    Start = 1'b0; Abort = 1'b0; Resetn = 1'b1;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dds_sweep_sequencer.md
Name: dds_sweep_sequencer

Overview:
Automatic frequency-sweep controller for the DDS oscillator path. It steps the 11-bit coefficient-table address from a start to a stop index, dwelling a programmable number of oscillator samples per step. It issues the FreqChng reload strobe once the table coefficients for the new address are valid. It sits beside Rotary (same address/FreqChng targets, muxed externally by the top level) and is clocked on Fg_clk.

Parameters:
ADDR_W, 11, table address width
DWELL_W, 16, width of the dwell-count input
TABLE_LAT, 1, Fg_clk cycles from an address change to valid sine1x/cos2x at the table output (legal 1..3)

Ports:
Fg_clk  input  1  fabric clock, all logic on rising edge
Resetn  input  1  synchronous active-low reset
Start  input  1  single-cycle pulse; starts a sweep when idle
Abort  input  1  level; returns to IDLE immediately
Loop  input  1  sampled at each end-of-sweep; 1 = restart from start_addr
Ready  input  1  oscillator sample strobe, one cycle per output sample
start_addr  input  ADDR_W  first table index, latched on accepted Start
stop_addr  input  ADDR_W  last table index, latched on accepted Start
step  input  ADDR_W  address increment magnitude, latched on Start
dwell  input  DWELL_W  Ready pulses per step, latched on Start
address  output  ADDR_W  table address to Table_coef
FreqChng  output  1  one-cycle coefficient reload strobe to Oscillator
Busy  output  1  high in any state other than IDLE and DONE
Done  output  1  one-cycle pulse at end of a non-looping sweep

Behaviour:
- Reset (Resetn=0 at a clock edge): state IDLE, address=0, FreqChng=0, Busy=0, Done=0, dwell counter=0, latency counter=0, all latched config=0.
- States: IDLE, SETTLE, DWELL, STEP, DONE.
- IDLE: on Start=1, latch config and set address=start_addr. Go to SETTLE and set Busy=1 in the next cycle. Start while Busy is ignored.
- Zero-value handling: step=0 is treated as 1. dwell=0 is treated as 1.
- Direction is fixed at Start: ascending if stop_addr>=start_addr, else descending.
- SETTLE: wait TABLE_LAT cycles after the address update. Pulse FreqChng for exactly 1 cycle in the final SETTLE cycle, then go to DWELL with the dwell counter cleared.
- DWELL: count Ready pulses. Ready arriving in the same cycle as the FreqChng pulse is not counted. When count reaches dwell, go to STEP.
- STEP, address==stop_addr: end of sweep.
  - Loop=1: address=start_addr, go to SETTLE.
  - Loop=0: go to DONE.
- STEP, otherwise: next = address ± step, clamped to stop_addr if it would pass stop_addr. Unsigned arithmetic in ADDR_W+1 bits, so there is no wrap at 0 or 2047. Go to SETTLE.
- The address changes only in STEP or on an accepted Start.
- DONE: Done=1 for one cycle, Busy=0, address holds the last value, then IDLE.
- Abort=1: next state IDLE, address held, no FreqChng or Done. Abort has priority over Start and every transition, including one arriving in the same cycle.
- start_addr==stop_addr: one SETTLE plus DWELL, then end of sweep.
- Input changes while Busy have no effect until the next accepted Start.
- Synchronous reset mid-sweep behaves like the reset values above, with no residual pulse.

Optional Feature:
Macro SWEEP_PINGPONG_EN.
- Defined: at end of sweep with Loop=1, the direction reverses instead of reloading start_addr. The next address is computed toward the opposite endpoint with the same clamp. Endpoints are dwelt once per pass, not twice.
- Undefined: looping always reloads start_addr, as specified above.
- Loop=0 behaviour is identical in both builds.

Test Plan:
1. start=10, stop=13, step=1, dwell=2, Loop=0, Ready every 4 cycles -> address 10,11,12,13. Each FreqChng pulse comes TABLE_LAT cycles after its address change. Exactly 2 Ready pulses between FreqChng pulses. Done pulses once, Busy falls with it.
2. start=2040, stop=2047, step=5 -> address 2040, 2045, 2047 (clamped). No wrap to low addresses. Then Done.
3. start=20, stop=5, step=7, dwell=0 -> address 20, 13, 6, 5. dwell is treated as 1 Ready per step.
4. Loop=1, start=3, stop=4, step=1, dwell=1 -> address cycles 3,4,3,4 with no Done. With SWEEP_PINGPONG_EN and stop=5: 3,4,5,4,3,4.
5. Abort asserted in DWELL, and separately Abort together with Start in IDLE -> IDLE next cycle, Busy=0, address unchanged, no FreqChng or Done. A Start pulse mid-sweep is ignored.
6. Resetn=0 for 1 cycle during SETTLE -> all outputs 0 the next cycle. A new Start then sweeps normally.
